// File: rtl/vault_pkg.sv
// Shared definitions for the credential-slot store.
// Contents:
//   VAULT_DATA_W  default entry width (one encrypted credential record)
//   VAULT_DEPTH   default slot count (power of two, 2..256)
//   vault_state_t store controller state: IDLE (serving commands) or
//                 ERASE (secure-erase sweep in progress)
package vault_pkg;

    localparam int VAULT_DATA_W = 256;
    localparam int VAULT_DEPTH  = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ERASE = 1'b1
    } vault_state_t;

endpackage

// File: rtl/vault_entry_mem.sv
// Simple dual-port entry memory: one write port, one registered read port.
// The array carries no reset so it maps onto block RAM; the owner masks the
// read data with its valid bits.  A read and a write to the same slot in the
// same cycle return the old contents (read-before-write).
// Ports:
//   clk    clock
//   we     write enable
//   waddr  write slot
//   wdata  write data
//   re     read enable (rdata holds when low)
//   raddr  read slot
//   rdata  registered read data, one cycle after re
module vault_entry_mem
    import vault_pkg::*;
#(
    parameter int DATA_W = VAULT_DATA_W,
    parameter int DEPTH  = VAULT_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_array [DEPTH];
    logic [DATA_W-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_array[waddr] <= wdata;
        end
        if (re) begin
            rdata_reg <= mem_array[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/vault_entry_store.sv
// Credential-slot store: DEPTH x DATA_W memory with per-slot valid bits,
// overwrite, append-to-lowest-free-slot, delete, live occupancy count and a
// hardware secure-erase sweep that zeroes every slot after reset or clr.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   clr                 start secure-erase sweep
//   wr_en/wr_addr       write wr_data to a given slot
//   app_en              write wr_data to the lowest free slot
//   wr_data             write/append data
//   del_en/del_addr     invalidate a slot
//   rd_en/rd_addr       read request
//   rd_data/rd_valid/rd_hit  read response, one cycle after rd_en
//   app_addr/app_ok     slot of the last accepted append / accept pulse
//   count/full/empty    occupancy
//   busy                erase sweep in progress
//   err                 one-cycle pulse for a rejected command
module vault_entry_store
    import vault_pkg::*;
#(
    parameter int DATA_W = VAULT_DATA_W,
    parameter int DEPTH  = VAULT_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              app_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              del_en,
    input  logic [ADDR_W-1:0] del_addr,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_hit,
    output logic [ADDR_W-1:0] app_addr,
    output logic              app_ok,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              busy,
    output logic              err
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);

    vault_state_t      state_reg, state_next;
    logic [ADDR_W-1:0] idx_reg, idx_next;
    logic [DEPTH-1:0]  valid_reg, valid_next;
    logic [ADDR_W:0]   count_reg, count_next;
    logic [ADDR_W-1:0] app_addr_reg, app_addr_next;
    logic              app_ok_reg, app_ok_next;
    logic              rd_valid_reg, rd_valid_next;
    logic              rd_hit_reg, rd_hit_next;
    logic              err_reg, err_next;

    logic              all_valid;
    logic [ADDR_W-1:0] free_idx;
    logic              w_do, del_do, rd_go;
    logic [ADDR_W-1:0] w_addr;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [DEPTH-1:0]  w_hit, d_hit;

    assign all_valid = &valid_reg;

    // Lowest-index free slot; scanning downward lets the lowest index win.
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_reg[i]) begin
                free_idx = ADDR_W'(i);
            end
        end
    end

    // Controller: state/sweep index plus command arbitration.
    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        count_next    = count_reg;
        app_addr_next = app_addr_reg;
        app_ok_next   = 1'b0;
        rd_valid_next = 1'b0;
        rd_hit_next   = rd_hit_reg;
        err_next      = 1'b0;
        w_do          = 1'b0;
        w_addr        = wr_addr;
        del_do        = 1'b0;
        rd_go         = 1'b0;
        mem_we        = 1'b0;
        mem_waddr     = idx_reg;
        mem_wdata     = '0;

        if (clr) begin
            // Restart the sweep; any command in this cycle is dropped.
            state_next  = ST_ERASE;
            idx_next    = '0;
            count_next  = '0;
            rd_hit_next = 1'b0;
        end else if (state_reg == ST_ERASE) begin
            mem_we    = 1'b1;
            mem_waddr = idx_reg;
            idx_next  = idx_reg + 1'b1;
            if (idx_reg == LAST_IDX) begin
                state_next = ST_IDLE;
            end
            err_next = wr_en | app_en | del_en | rd_en;
        end else begin
            // Conflicting wr_en + app_en rejects both; delete/read still run.
            if (wr_en && app_en) begin
                err_next = 1'b1;
            end else if (wr_en) begin
                w_do   = 1'b1;
                w_addr = wr_addr;
            end else if (app_en) begin
                if (all_valid) begin
                    err_next = 1'b1;
                end else begin
                    w_do          = 1'b1;
                    w_addr        = free_idx;
                    app_addr_next = free_idx;
                    app_ok_next   = 1'b1;
                end
            end

            // A delete colliding with a write to the same slot is silently
            // dropped so the write wins.
            if (del_en && !(w_do && (w_addr == del_addr))) begin
                if (valid_reg[del_addr]) begin
                    del_do = 1'b1;
                end else begin
                    err_next = 1'b1;
                end
            end

            count_next = count_reg
                       + (ADDR_W + 1)'(w_do && !valid_reg[w_addr])
                       - (ADDR_W + 1)'(del_do);

            // One write port: a data write takes it first.  A delete that
            // loses the port leaves stale bytes behind, but the cleared valid
            // bit masks them on every read until the slot is rewritten or swept.
            if (w_do) begin
                mem_we    = 1'b1;
                mem_waddr = w_addr;
                mem_wdata = wr_data;
            end else if (del_do) begin
                mem_we    = 1'b1;
                mem_waddr = del_addr;
            end

            if (rd_en) begin
                rd_go         = 1'b1;
                rd_valid_next = 1'b1;
                rd_hit_next   = valid_reg[rd_addr];
            end
        end
    end

    // Per-slot valid bit update.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
            assign w_hit[gi] = w_do && (w_addr == ADDR_W'(gi));
            assign d_hit[gi] = del_do && (del_addr == ADDR_W'(gi));
            assign valid_next[gi] = clr ? 1'b0
                                        : (w_hit[gi] | (valid_reg[gi] & ~d_hit[gi]));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_ERASE;
            idx_reg      <= '0;
            valid_reg    <= '0;
            count_reg    <= '0;
            app_addr_reg <= '0;
            app_ok_reg   <= 1'b0;
            rd_valid_reg <= 1'b0;
            rd_hit_reg   <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            valid_reg    <= valid_next;
            count_reg    <= count_next;
            app_addr_reg <= app_addr_next;
            app_ok_reg   <= app_ok_next;
            rd_valid_reg <= rd_valid_next;
            rd_hit_reg   <= rd_hit_next;
            err_reg      <= err_next;
        end
    end

    vault_entry_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (rd_go),
        .raddr (rd_addr),
        .rdata (mem_rdata)
    );

    // The memory output has no reset; the hit flag gates it so invalid slots
    // and the post-reset state always read as zero.
    assign rd_data  = rd_hit_reg ? mem_rdata : '0;
    assign rd_valid = rd_valid_reg;
    assign rd_hit   = rd_hit_reg;
    assign app_addr = app_addr_reg;
    assign app_ok   = app_ok_reg;
    assign count    = count_reg;
    assign full     = (count_reg == FULL_CNT);
    assign empty    = (count_reg == '0);
    assign busy     = (state_reg == ST_ERASE);
    assign err      = err_reg;

endmodule

// File: tb/tb_vault_entry_store.sv
// Directed bench for vault_entry_store with default parameters (16 x 256).
module tb_vault_entry_store;

    localparam int W      = 256;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              clr;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              app_en;
    logic [W-1:0]      wr_data;
    logic              del_en;
    logic [ADDR_W-1:0] del_addr;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [W-1:0]      rd_data;
    logic              rd_valid;
    logic              rd_hit;
    logic [ADDR_W-1:0] app_addr;
    logic              app_ok;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              busy;
    logic              err;

    int n_checks = 0;
    int n_pass   = 0;
    int n;

    always #5 clk = ~clk;

    vault_entry_store #(
        .DATA_W (W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .app_en   (app_en),
        .wr_data  (wr_data),
        .del_en   (del_en),
        .del_addr (del_addr),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_hit   (rd_hit),
        .app_addr (app_addr),
        .app_ok   (app_ok),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .busy     (busy),
        .err      (err)
    );

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_cmds();
        clr    = 1'b0;
        wr_en  = 1'b0;
        app_en = 1'b0;
        del_en = 1'b0;
        rd_en  = 1'b0;
    endtask

    // Apply the currently driven command for one clock, then sample #1 later.
    task automatic step(input string what);
        @(posedge clk);
        #1;
        $display("[%0t] %s: rd_valid=%0b rd_hit=%0b rd_data=%0h app_ok=%0b app_addr=%0d err=%0b count=%0d busy=%0b",
                 $time, what, rd_valid, rd_hit, rd_data, app_ok, app_addr, err, count, busy);
        clear_cmds();
    endtask

    initial begin
        rst      = 1'b1;
        clear_cmds();
        wr_addr  = '0;
        del_addr = '0;
        rd_addr  = '0;
        wr_data  = '0;

        // Reset state
        step("reset");
        rst = 1'b0;
        check_val("rst_busy",     W'(busy), 1);
        check_val("rst_count",    W'(count), 0);
        check_val("rst_empty",    W'(empty), 1);
        check_val("rst_full",     W'(full), 0);
        check_val("rst_rd_valid", W'(rd_valid), 0);
        check_val("rst_rd_hit",   W'(rd_hit), 0);
        check_val("rst_rd_data",  rd_data, 0);
        check_val("rst_app_ok",   W'(app_ok), 0);
        check_val("rst_app_addr", W'(app_addr), 0);
        check_val("rst_err",      W'(err), 0);

        // Sweep after reset lasts DEPTH cycles
        n = 1;
        while (busy && n < 40) begin
            step("sweep");
            n++;
        end
        check_val("rst_sweep_len", W'(n), 17);
        check_val("post_sweep_count", W'(count), 0);
        check_val("post_sweep_empty", W'(empty), 1);

        rd_en = 1'b1; rd_addr = 5;
        step("read5");
        check_val("rd5_valid", W'(rd_valid), 1);
        check_val("rd5_hit",   W'(rd_hit), 0);
        check_val("rd5_data",  rd_data, 0);

        // Fill every slot by append
        for (int i = 0; i < DEPTH; i++) begin
            app_en = 1'b1; wr_data = W'('hA0 + i);
            step("append");
            check_val("app_ok",   W'(app_ok), 1);
            check_val("app_addr", W'(app_addr), W'(i));
        end
        check_val("fill_err",   W'(err), 0);
        check_val("fill_count", W'(count), 16);
        check_val("fill_full",  W'(full), 1);
        check_val("fill_rd_valid_idle", W'(rd_valid), 0);

        app_en = 1'b1; wr_data = 'hEE;
        step("append_full");
        check_val("app17_err",      W'(err), 1);
        check_val("app17_ok",       W'(app_ok), 0);
        check_val("app17_count",    W'(count), 16);
        check_val("app17_app_addr", W'(app_addr), 15);

        // Delete then refill the hole
        del_en = 1'b1; del_addr = 3;
        step("del3");
        check_val("del3_count", W'(count), 15);
        check_val("del3_full",  W'(full), 0);

        app_en = 1'b1; wr_data = 'hBB;
        step("append_bb");
        check_val("appbb_addr",  W'(app_addr), 3);
        check_val("appbb_count", W'(count), 16);

        rd_en = 1'b1; rd_addr = 3;
        step("read3");
        check_val("rd3_data", rd_data, 'hBB);
        check_val("rd3_hit",  W'(rd_hit), 1);

        // Overwrite of a valid slot
        wr_en = 1'b1; wr_addr = 2; wr_data = 'h22;
        step("wr2");
        check_val("wr2_count", W'(count), 16);

        // Write and delete of the same slot: write wins
        wr_en = 1'b1; wr_addr = 2; wr_data = 'h23;
        del_en = 1'b1; del_addr = 2;
        step("wr2_del2");
        check_val("wrdel_count", W'(count), 16);
        rd_en = 1'b1; rd_addr = 2;
        step("read2");
        check_val("rd2_hit",  W'(rd_hit), 1);
        check_val("rd2_data", rd_data, 'h23);

        // Delete of an invalid slot
        del_en = 1'b1; del_addr = 4;
        step("del4");
        check_val("del4_count", W'(count), 15);
        check_val("del4_err",   W'(err), 0);
        del_en = 1'b1; del_addr = 4;
        step("del4_again");
        check_val("del4b_err",   W'(err), 1);
        check_val("del4b_count", W'(count), 15);

        // wr_en and app_en together: rejected
        wr_en = 1'b1; app_en = 1'b1; wr_addr = 9; wr_data = 'h99;
        step("wr_app_conflict");
        check_val("conf_err",   W'(err), 1);
        check_val("conf_ok",    W'(app_ok), 0);
        check_val("conf_count", W'(count), 15);
        rd_en = 1'b1; rd_addr = 9;
        step("read9");
        check_val("rd9_data", rd_data, 'hA9);

        // Read-before-write on the same slot
        rd_en = 1'b1; rd_addr = 7;
        wr_en = 1'b1; wr_addr = 7; wr_data = 'h55;
        step("read7_wr7");
        check_val("rbw_data",  rd_data, 'hA7);
        check_val("rbw_count", W'(count), 15);
        rd_en = 1'b1; rd_addr = 7;
        step("read7");
        check_val("rd7_data", rd_data, 'h55);

        // Write and delete on different slots: net count change zero
        wr_en = 1'b1; wr_addr = 4; wr_data = 'h44;
        del_en = 1'b1; del_addr = 5;
        step("wr4_del5");
        check_val("wr4del5_count", W'(count), 15);
        rd_en = 1'b1; rd_addr = 5;
        step("read5b");
        check_val("rd5b_hit",  W'(rd_hit), 0);
        check_val("rd5b_data", rd_data, 0);
        rd_en = 1'b1; rd_addr = 4;
        step("read4");
        check_val("rd4_data", rd_data, 'h44);

        // Secure erase, restarted mid-sweep at idx 9
        clr = 1'b1;
        step("clr");
        check_val("clr_busy",  W'(busy), 1);
        check_val("clr_count", W'(count), 0);
        check_val("clr_empty", W'(empty), 1);
        for (int i = 0; i < 9; i++) begin
            step("sweep");
        end
        check_val("mid_busy", W'(busy), 1);
        clr = 1'b1;
        step("clr_again");
        wr_en = 1'b1; wr_addr = 0; wr_data = 'h77;
        step("wr_busy");
        check_val("busy_err",   W'(err), 1);
        check_val("busy_count", W'(count), 0);
        n = 2;
        while (busy && n < 40) begin
            step("sweep");
            n++;
        end
        check_val("clr_sweep_len", W'(n), 17);
        rd_en = 1'b1; rd_addr = 0;
        step("read0");
        check_val("rd0_hit",  W'(rd_hit), 0);
        check_val("rd0_data", rd_data, 0);
        check_val("final_count", W'(count), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vault_entry_store.md
# vault_entry_store

Parametrised credential-slot store for the password vault datapath: a DEPTH x DATA_W memory with per-slot valid bits, append-to-first-free-slot, overwrite, delete, live occupancy count and a hardware secure-erase sweep. It sits between the command decoder and the crypto engine and replaces the fixed 16 x 256 store, whose plain write counter over-counted on overwrites and wrapped silently.

## Interface
- DATA_W, 256, entry width in bits (encrypted credential record)
- DEPTH, 16, number of slots; power of two, 2..256
- ADDR_W, $clog2(DEPTH), slot index width
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- clr  in  1  start secure-erase sweep (single-cycle pulse)
- wr_en  in  1  write wr_data to slot wr_addr (overwrite allowed)
- wr_addr  in  ADDR_W  write slot
- app_en  in  1  write wr_data to lowest-index free slot
- wr_data  in  DATA_W  write/append data
- del_en  in  1  invalidate slot del_addr
- del_addr  in  ADDR_W  delete slot
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  read slot
- rd_data  out  DATA_W  registered read data; 0 when slot invalid
- rd_valid  out  1  one-cycle pulse, rd_data/rd_hit valid
- rd_hit  out  1  addressed slot held a valid entry
- app_addr  out  ADDR_W  slot used by last successful append
- app_ok  out  1  one-cycle pulse, append accepted
- count  out  ADDR_W+1  number of valid slots, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- busy  out  1  erase sweep in progress
- err  out  1  one-cycle pulse: rejected command

## Operation
- Priority: rst > clr > sweep in progress > {del, wr/app, rd}.
- rst: valid bits cleared, count=0, FSM enters ERASE at slot 0. Reset values: rd_data=0, rd_valid=0, rd_hit=0, app_addr=0, app_ok=0, err=0, busy=1 from the cycle after rst, full=0, empty=1.
- FSM IDLE/ERASE. ERASE writes 0 to slot idx, idx increments each cycle; after slot DEPTH-1, returns to IDLE (busy=0). clr in IDLE or ERASE: valid bits cleared, count=0, idx restarts at 0.
- During ERASE any wr_en/app_en/del_en/rd_en is dropped and err pulses; no state change.
- wr_en: slot written, valid set; count +1 only if slot was invalid.
- app_en: priority encoder picks lowest invalid slot; write, set valid, count +1, app_addr updated, app_ok pulses. If full: no write, err pulses, app_addr unchanged.
- wr_en and app_en together: err, neither performed.
- del_en on valid slot: valid cleared, data zeroed, count -1. On invalid slot: no-op, err pulses.
- del_en and write (wr or app) to same slot same cycle: write wins, delete ignored, count reflects write only. Different slots: both performed, count net-adjusted.
- rd: read-before-write; same-cycle write/delete to rd_addr returns old contents.
- count never wraps; full/empty derived combinationally from count.

## Timing
- Read latency 1: rd_en at cycle N -> rd_valid, rd_data, rd_hit at N+1.
- Write/append/delete visible to a read issued the following cycle.
- count/full/empty update the cycle after the command.
- Erase sweep: exactly DEPTH cycles busy after rst or last clr.
- No back-pressure; one command set accepted per cycle when busy=0.

## Structure
- Shared package vault_pkg: DATA_W and DEPTH defaults, ERASE/IDLE state enum.
- Sub-module vault_entry_mem: simple dual-port memory (one write port, one registered read port), no reset on the array, so it maps to block RAM; valid bits, count, encoder and FSM live in the top.

## Test plan
- rst, wait 16 cycles -> busy 1 for cycles 1..16, then 0; count=0, empty=1; read slot 5 -> rd_data=0, rd_hit=0.
- 16 appends of 0xA0..0xAF -> app_addr 0..15, count 16, full=1; 17th append -> err pulse, count stays 16.
- Delete slot 3, append 0xBB -> app_addr=3, count back to 16; read slot 3 -> 0xBB, rd_hit=1.
- wr_en slot 2 on valid slot -> count unchanged; wr_en + del_en same slot -> slot valid, count unchanged; del invalid slot -> err.
- Read slot 7 same cycle as write 0x55 to slot 7 -> returns old value; next read returns 0x55.
- clr mid-sweep at idx 9 -> sweep restarts, busy for 16 more cycles; command during busy -> err, no effect.
